elbeth_mem_wb_stage: RTL and testbench
======================================

ELBETH_MEM_WB_STAGE -- requirements
Module: elbeth_mem_wb_stage

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 255, max cycles a load waits on dmem_ready before timeout.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall  input  1  hazard-unit stall; hold WB register.
REQ-005 SHALL have port flush  input  1  hazard-unit flush; load bubble into WB register.
REQ-006 SHALL have ports mem_alu_result, mem_pc_plus4, mem_csr_data  input  32 each  MEM-stage candidate writeback values.
REQ-007 SHALL have port mem_rd_addr  input  5  destination register.
REQ-008 SHALL have port mem_rf_we  input  1  register-file write enable.
REQ-009 SHALL have port mem_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-010 SHALL have port mem_is_load  input  1  MEM instruction is a load.
REQ-011 SHALL have port mem_load_type  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 SHALL have ports dmem_rdata  input  32 and dmem_ready  input  1  data-memory read word and valid.
REQ-013 SHALL have ports wb_alu_result, wb_load_data, wb_pc_plus4, wb_csr_data  output  32 each  the four inputs of the downstream 4:1 writeback mux, in select order 00..11.
REQ-014 SHALL have ports wb_sel  output  2, wb_rd_addr  output  5, wb_rf_we  output  1  registered writeback control.
REQ-015 SHALL have ports mem_stall_req  output  1, load_misaligned  output  1, dmem_timeout  output  1  status to hazard/trap logic.

Function
REQ-016 SHALL be one pipeline register: WB outputs change one cycle after MEM inputs are captured.
REQ-017 SHALL apply priority per edge: rst > flush > stall > load-wait bubble > normal capture.
REQ-018 SHALL on flush load a bubble: wb_rf_we=0, wb_rd_addr=0, wb_sel=00, data outputs 0.
REQ-019 SHALL on stall (no flush) hold every WB output and FSM state unchanged.
REQ-020 SHALL run FSM IDLE/WAIT: IDLE->WAIT when mem_is_load & !dmem_ready & !stall & !flush; WAIT->IDLE when dmem_ready, flush, or timeout.
REQ-021 SHALL drive mem_stall_req combinationally = mem_is_load & !dmem_ready & !dmem_timeout.
REQ-022 SHALL insert a bubble into WB each cycle mem_stall_req is high; capture the load when dmem_ready is seen.
REQ-023 SHALL count WAIT cycles in an 8-bit counter cleared on entering WAIT; at count==WAIT_LIMIT assert dmem_timeout (sticky until rst), return IDLE, capture bubble.
REQ-024 SHALL align loads by mem_alu_result[1:0]: LB/LBU select byte at offset, LH/LHU halfword at offset[1]*16, LW whole word.
REQ-025 SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; unused load types yield 0.
REQ-026 SHALL flag misaligned when LH/LHU with addr[0]=1 or LW with addr[1:0]!=0; then register load_misaligned=1 for one cycle and force wb_rf_we=0.
REQ-027 SHALL force wb_rf_we=0 when mem_rd_addr==0.
REQ-028 SHALL when dmem_ready arrives in the same cycle as flush discard the load data (flush wins).

Reset
REQ-029 SHALL on rst: FSM=IDLE, counter=0, all WB outputs 0, load_misaligned=0, dmem_timeout=0.
REQ-030 SHALL on rst mid-WAIT abandon the pending load; no writeback occurs for it.

Structure
REQ-031 SHALL take wb_sel encodings, load_type encodings and FSM state codes from shared package elbeth_defs.
REQ-032 SHALL place alignment/extension in combinational sub-module elbeth_load_align.

Verification
REQ-033 SHALL cover: LB addr 0x...3, dmem_rdata=0x80112233, ready=1 -> next cycle wb_load_data=0xFFFFFF80, wb_sel=01, wb_rf_we=1.
REQ-034 SHALL cover: LHU addr 0x...2, rdata=0xBEEF1234 -> wb_load_data=0x0000BEEF; LH same -> 0xFFFFBEEF.
REQ-035 SHALL cover: LW with ready low 3 cycles -> mem_stall_req high 3 cycles, 3 bubbles (wb_rf_we=0), data captured on 4th edge.
REQ-036 SHALL cover: WAIT_LIMIT=4, ready never asserted -> dmem_timeout=1 after 4 WAIT cycles, mem_stall_req drops, wb_rf_we=0.
REQ-037 SHALL cover: LW addr 0x...2 -> load_misaligned pulses 1 cycle, wb_rf_we=0; flush+stall together -> bubble loaded.
REQ-038 SHALL cover: rd=0 with rf_we=1 -> wb_rf_we=0; rst asserted in WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/elbeth_mem_wb_stage_pkg.sv
// Shared encodings for the MEM/WB stage: writeback select, load types and
// the load-wait FSM states, plus the alignment rule used by the load path.
package elbeth_defs;

    localparam int XLEN  = 32;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10,
        WB_CSR  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } load_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic load_is_misaligned(input logic [2:0] load_type,
                                                input logic [1:0] offset);
        logic w_half;
        w_half = (load_type == LT_LH) || (load_type == LT_LHU);
        return (w_half && offset[0]) || ((load_type == LT_LW) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/elbeth_load_align.sv
// Combinational load formatter: picks the byte/halfword/word addressed by the
// low address bits and sign- or zero-extends it to a full register.
module elbeth_load_align
    import elbeth_defs::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_offset,
    input  logic [2:0]      i_load_type,
    output logic [XLEN-1:0] o_data,
    output logic            o_misaligned
);

    logic signed [7:0]  w_byte;
    logic signed [15:0] w_half;

    assign w_byte       = i_rdata[{i_offset, 3'b000} +: 8];
    assign w_half       = i_rdata[{i_offset[1], 4'b0000} +: 16];
    assign o_misaligned = load_is_misaligned(i_load_type, i_offset);

    always_comb begin
        o_data = '0;
        case (i_load_type)
            LT_LB:   o_data = XLEN'(w_byte);
            LT_LH:   o_data = XLEN'(w_half);
            LT_LW:   o_data = i_rdata;
            LT_LBU:  o_data = XLEN'($unsigned(w_byte));
            LT_LHU:  o_data = XLEN'($unsigned(w_half));
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/elbeth_mem_wb_stage.sv
// MEM/WB pipeline register with load-wait handling: bubbles WB while a load
// waits on data memory, times out after WAIT_LIMIT wait cycles, flags misalignment.
module elbeth_mem_wb_stage
    import elbeth_defs::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] mem_alu_result,
    input  logic [XLEN-1:0] mem_pc_plus4,
    input  logic [XLEN-1:0] mem_csr_data,
    input  logic [4:0]      mem_rd_addr,
    input  logic            mem_rf_we,
    input  logic [1:0]      mem_wb_sel,
    input  logic            mem_is_load,
    input  logic [2:0]      mem_load_type,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [XLEN-1:0] wb_load_data,
    output logic [XLEN-1:0] wb_pc_plus4,
    output logic [XLEN-1:0] wb_csr_data,
    output logic [1:0]      wb_sel,
    output logic [4:0]      wb_rd_addr,
    output logic            wb_rf_we,
    output logic            mem_stall_req,
    output logic            load_misaligned,
    output logic            dmem_timeout
);

    logic [XLEN-1:0]  w_aligned;
    logic             w_align_mis;
    logic             w_misaligned;
    logic             w_load_pending;
    logic             w_take;
    logic             w_limit_hit;
    logic [CNT_W:0]   w_cnt_inc;

    mem_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_timeout;
    logic [XLEN-1:0]  r_alu;
    logic [XLEN-1:0]  r_load;
    logic [XLEN-1:0]  r_pc4;
    logic [XLEN-1:0]  r_csr;
    logic [1:0]       r_sel;
    logic [4:0]       r_rd;
    logic             r_we;
    logic             r_mis;

    elbeth_load_align u_align (
        .i_rdata      (dmem_rdata),
        .i_offset     (mem_alu_result[1:0]),
        .i_load_type  (mem_load_type),
        .o_data       (w_aligned),
        .o_misaligned (w_align_mis)
    );

    assign w_misaligned   = mem_is_load & w_align_mis;
    assign w_load_pending = mem_is_load & ~dmem_ready;
    assign mem_stall_req  = w_load_pending & ~r_timeout;
    assign w_cnt_inc      = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_limit_hit    = (w_cnt_inc == (CNT_W + 1)'(WAIT_LIMIT));

    // A load without data never reaches WB, even once the timeout has fired.
    assign w_take = ~flush & ~stall & ~w_load_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else if (flush) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (!stall) begin
            if (mem_stall_req) begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_WAIT;
                        r_cnt   <= '0;
                    end
                    ST_WAIT: begin
                        if (w_limit_hit) begin
                            r_timeout <= 1'b1;
                            r_state   <= ST_IDLE;
                            r_cnt     <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc[CNT_W-1:0];
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end else begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end
        end
    end

    // MEM -> WB register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu  <= '0;
            r_load <= '0;
            r_pc4  <= '0;
            r_csr  <= '0;
            r_sel  <= WB_ALU;
            r_rd   <= '0;
            r_we   <= 1'b0;
            r_mis  <= 1'b0;
        end else if (flush || !stall) begin
            r_alu  <= w_take ? mem_alu_result : '0;
            r_load <= (w_take && mem_is_load) ? w_aligned : '0;
            r_pc4  <= w_take ? mem_pc_plus4 : '0;
            r_csr  <= w_take ? mem_csr_data : '0;
            r_sel  <= w_take ? mem_wb_sel : WB_ALU;
            r_rd   <= w_take ? mem_rd_addr : '0;
            r_we   <= w_take & mem_rf_we & (mem_rd_addr != 5'd0) & ~w_misaligned;
            r_mis  <= w_take & w_misaligned;
        end else begin
            r_mis <= 1'b0;
        end
    end

    assign wb_alu_result   = r_alu;
    assign wb_load_data    = r_load;
    assign wb_pc_plus4     = r_pc4;
    assign wb_csr_data     = r_csr;
    assign wb_sel          = r_sel;
    assign wb_rd_addr      = r_rd;
    assign wb_rf_we        = r_we;
    assign load_misaligned = r_mis;
    assign dmem_timeout    = r_timeout;

endmodule

// File: tb/tb_elbeth_mem_wb_stage.sv
// Self-checking bench for elbeth_mem_wb_stage: directed corner cases followed
// by randomized cycles, all compared against a behavioural model.
module tb_elbeth_mem_wb_stage;

    localparam int LIMIT = 4;

    logic        clk;
    logic        rst, stall, flush;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_csr_data;
    logic [4:0]  mem_rd_addr;
    logic        mem_rf_we;
    logic [1:0]  mem_wb_sel;
    logic        mem_is_load;
    logic [2:0]  mem_load_type;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] wb_alu_result, wb_load_data, wb_pc_plus4, wb_csr_data;
    logic [1:0]  wb_sel;
    logic [4:0]  wb_rd_addr;
    logic        wb_rf_we, mem_stall_req, load_misaligned, dmem_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [31:0] e_alu, e_ld, e_pc, e_csr;
    logic [1:0]  e_sel;
    logic [4:0]  e_rd;
    logic        e_we, e_mis;
    bit          m_wait, m_to;
    int          m_wcnt;
    logic        stall_seen;

    elbeth_mem_wb_stage #(.WAIT_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_csr_data(mem_csr_data), .mem_rd_addr(mem_rd_addr),
        .mem_rf_we(mem_rf_we), .mem_wb_sel(mem_wb_sel),
        .mem_is_load(mem_is_load), .mem_load_type(mem_load_type),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .wb_alu_result(wb_alu_result), .wb_load_data(wb_load_data),
        .wb_pc_plus4(wb_pc_plus4), .wb_csr_data(wb_csr_data),
        .wb_sel(wb_sel), .wb_rd_addr(wb_rd_addr), .wb_rf_we(wb_rf_we),
        .mem_stall_req(mem_stall_req), .load_misaligned(load_misaligned),
        .dmem_timeout(dmem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_align(input logic [2:0] lt, input logic [1:0] a, input logic [31:0] d);
        int b, h;
        b = int'((d >> (8 * int'(a))) & 32'hFF);
        h = int'((d >> (a[1] ? 16 : 0)) & 32'hFFFF);
        case (lt)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd2:    return d;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_misal(input logic [2:0] lt, input logic [1:0] a);
        if ((lt == 3'd1 || lt == 3'd5) && (a % 2 == 1)) return 1'b1;
        if (lt == 3'd2 && a != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_bubble;
        e_alu = 0; e_ld = 0; e_pc = 0; e_csr = 0;
        e_sel = 0; e_rd = 0; e_we = 0; e_mis = 0;
    endtask

    task automatic m_step;
        bit mis;
        mis = mem_is_load && m_misal(mem_load_type, mem_alu_result[1:0]);
        if (rst) begin
            m_bubble(); m_wait = 0; m_wcnt = 0; m_to = 0;
        end else if (flush) begin
            m_bubble(); m_wait = 0; m_wcnt = 0;
        end else if (stall) begin
            e_mis = 0;
        end else if (mem_is_load && !dmem_ready) begin
            m_bubble();
            if (m_to) m_wait = 0;
            else if (!m_wait) begin m_wait = 1; m_wcnt = 0; end
            else begin
                m_wcnt++;
                if (m_wcnt == LIMIT) begin m_to = 1; m_wait = 0; end
            end
        end else begin
            e_alu = mem_alu_result;
            e_ld  = mem_is_load ? m_align(mem_load_type, mem_alu_result[1:0], dmem_rdata) : 0;
            e_pc  = mem_pc_plus4;
            e_csr = mem_csr_data;
            e_sel = mem_wb_sel;
            e_rd  = mem_rd_addr;
            e_we  = mem_rf_we && (mem_rd_addr != 0) && !mis;
            e_mis = mis;
            m_wait = 0;
        end
    endtask

    task automatic tick;
        #4;
        stall_seen = mem_stall_req;
        check_val("stall_req", 32'(stall_seen), 32'(mem_is_load && !dmem_ready && !m_to));
        @(posedge clk);
        m_step();
        #1;
        check_val("alu", wb_alu_result, e_alu);
        check_val("load", wb_load_data, e_ld);
        check_val("pc4", wb_pc_plus4, e_pc);
        check_val("csr", wb_csr_data, e_csr);
        check_val("sel", 32'(wb_sel), 32'(e_sel));
        check_val("rd", 32'(wb_rd_addr), 32'(e_rd));
        check_val("we", 32'(wb_rf_we), 32'(e_we));
        check_val("misal", 32'(load_misaligned), 32'(e_mis));
        check_val("timeout", 32'(dmem_timeout), 32'(m_to));
    endtask

    task automatic set_idle;
        rst = 0; stall = 0; flush = 0;
        mem_alu_result = 0; mem_pc_plus4 = 0; mem_csr_data = 0;
        mem_rd_addr = 0; mem_rf_we = 0; mem_wb_sel = 0;
        mem_is_load = 0; mem_load_type = 0; dmem_rdata = 0; dmem_ready = 1;
    endtask

    task automatic set_load(input logic [2:0] lt, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic rdy, input logic [4:0] rd);
        set_idle();
        mem_is_load = 1; mem_load_type = lt; mem_alu_result = addr;
        dmem_rdata = rdata; dmem_ready = rdy; mem_rd_addr = rd;
        mem_rf_we = 1; mem_wb_sel = 2'b01; mem_pc_plus4 = 32'h104; mem_csr_data = 32'h55;
    endtask

    initial begin
        set_idle();
        m_wait = 0; m_to = 0; m_wcnt = 0;
        m_bubble();
        rst = 1;
        tick();
        check_val("reset_we", 32'(wb_rf_we), 0);
        check_val("reset_alu", wb_alu_result, 0);

        set_load(3'b000, 32'h1000_0003, 32'h8011_2233, 1, 5'd5);
        tick();
        check_val("lb_data", wb_load_data, 32'hFFFF_FF80);
        check_val("lb_sel", 32'(wb_sel), 1);
        check_val("lb_we", 32'(wb_rf_we), 1);

        set_load(3'b101, 32'h1000_0002, 32'hBEEF_1234, 1, 5'd6);
        tick();
        check_val("lhu_data", wb_load_data, 32'h0000_BEEF);
        set_load(3'b001, 32'h1000_0002, 32'hBEEF_1234, 1, 5'd6);
        tick();
        check_val("lh_data", wb_load_data, 32'hFFFF_BEEF);

        set_load(3'b010, 32'h2000_0000, 32'hCAFE_F00D, 0, 5'd9);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("lw_wait_stall", 32'(stall_seen), 1);
            check_val("lw_wait_we", 32'(wb_rf_we), 0);
        end
        dmem_ready = 1;
        tick();
        check_val("lw_cap_data", wb_load_data, 32'hCAFE_F00D);
        check_val("lw_cap_we", 32'(wb_rf_we), 1);

        // ready arrives together with flush: data dropped
        set_load(3'b010, 32'h2000_0004, 32'h1111_2222, 0, 5'd9);
        tick();
        dmem_ready = 1; flush = 1;
        tick();
        check_val("flush_ready_we", 32'(wb_rf_we), 0);
        check_val("flush_ready_data", wb_load_data, 0);

        set_load(3'b010, 32'h3000_0002, 32'h1234_5678, 1, 5'd7);
        tick();
        check_val("misal_pulse", 32'(load_misaligned), 1);
        check_val("misal_we", 32'(wb_rf_we), 0);
        set_idle();
        tick();
        check_val("misal_clear", 32'(load_misaligned), 0);

        set_idle();
        mem_alu_result = 32'hABCD_0000; mem_rd_addr = 5'd3; mem_rf_we = 1;
        tick();
        check_val("alu_we", 32'(wb_rf_we), 1);
        stall = 1; flush = 1;
        tick();
        check_val("flush_stall_we", 32'(wb_rf_we), 0);
        check_val("flush_stall_alu", wb_alu_result, 0);
        check_val("flush_stall_rd", 32'(wb_rd_addr), 0);

        set_idle();
        mem_alu_result = 32'h77; mem_rd_addr = 5'd0; mem_rf_we = 1;
        tick();
        check_val("rd0_we", 32'(wb_rf_we), 0);

        // reset while waiting abandons the load
        set_load(3'b010, 32'h4000_0000, 32'hDEAD_BEEF, 0, 5'd4);
        tick();
        tick();
        rst = 1; dmem_ready = 1;
        tick();
        check_val("rst_wait_we", 32'(wb_rf_we), 0);
        check_val("rst_wait_data", wb_load_data, 0);
        check_val("rst_wait_pc", wb_pc_plus4, 0);

        set_load(3'b010, 32'h5000_0000, 32'h0, 0, 5'd8);
        for (int i = 0; i < LIMIT; i++) begin
            tick();
            check_val("to_pending", 32'(dmem_timeout), 0);
        end
        tick();
        check_val("to_set", 32'(dmem_timeout), 1);
        check_val("to_we", 32'(wb_rf_we), 0);
        tick();
        check_val("to_stall_drop", 32'(stall_seen), 0);
        rst = 1;
        tick();
        check_val("to_rst_clear", 32'(dmem_timeout), 0);

        for (int c = 0; c < 1500; c++) begin
            rst            = ($urandom_range(0, 99) < 2);
            flush          = ($urandom_range(0, 99) < 8);
            stall          = ($urandom_range(0, 99) < 15);
            mem_is_load    = ($urandom_range(0, 1) == 1);
            mem_load_type  = 3'($urandom_range(0, 7));
            mem_alu_result = $urandom;
            mem_pc_plus4   = $urandom;
            mem_csr_data   = $urandom;
            dmem_rdata     = $urandom;
            dmem_ready     = ($urandom_range(0, 99) < 60);
            mem_rf_we      = ($urandom_range(0, 3) != 0);
            mem_wb_sel     = 2'($urandom_range(0, 3));
            mem_rd_addr    = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
